dmem_arbiter: RTL

- Two-port round-robin arbiter and sequencer in front of the single-ported data memory.
- Port 0 serves the CPU load/store unit. Port 1 serves a debug/DMA master.
- Captures one request at a time, drives the memory for exactly one access cycle, registers the read data and returns a one-cycle response pulse to the winning requester.
- Sustained throughput is one transaction per 2 cycles.

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-ported data memory.
// One access cycle per transaction, response pulse one cycle later.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [2:0]        p0_width,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [2:0]        p1_width,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [2:0]        mem_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_gnt;
    logic               win_vld;
    logic               win_port;
    logic               h_port;
    logic               h_we;
    logic [2:0]         h_width;
    logic [ADDR_W-1:0]  h_addr;
    logic [DATA_W-1:0]  h_wdata;
    logic [DATA_W-1:0]  rdata_reg;
    logic [DATA_W-1:0]  rd_ext;
    logic               legal;

    assign legal = ~h_width[2];

    // Arbitration is only live in IDLE and RESP; a tie goes to the port not served last.
    always_comb begin
        win_vld  = 1'b0;
        win_port = 1'b0;
        if (state == IDLE || state == RESP) begin
            win_vld  = p0_req | p1_req;
            win_port = (p0_req && p1_req) ? ~last_gnt : p1_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = win_vld ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data zero-extended to the access width; writes and illegal widths return 0.
    always_comb begin
        rd_ext = '0;
        if (!h_we) begin
            case (h_width)
                3'd0:    rd_ext = DATA_W'(mem_rdata[7:0]);
                3'd1:    rd_ext = DATA_W'(mem_rdata[15:0]);
                3'd2:    rd_ext = DATA_W'(mem_rdata[31:0]);
                3'd3:    rd_ext = mem_rdata;
                default: rd_ext = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt  <= 1'b1;
            h_port    <= 1'b0;
            h_we      <= 1'b0;
            h_width   <= '0;
            h_addr    <= '0;
            h_wdata   <= '0;
            rdata_reg <= '0;
        end else begin
            if (win_vld) begin
                last_gnt <= win_port;
                h_port   <= win_port;
                h_we     <= win_port ? p1_we    : p0_we;
                h_width  <= win_port ? p1_width : p0_width;
                h_addr   <= win_port ? p1_addr  : p0_addr;
                h_wdata  <= win_port ? p1_wdata : p0_wdata;
            end
            if (state == ACCESS) rdata_reg <= rd_ext;
        end
    end

    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        p0_err    = 1'b0;
        p1_err    = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_width = h_width;
        mem_addr  = h_addr;
        mem_wdata = h_wdata;
        case (state)
            ACCESS: begin
                p0_gnt = ~h_port;
                p1_gnt = h_port;
                mem_we = legal & h_we;
                mem_re = legal & ~h_we;
            end
            RESP: begin
                if (h_port) begin
                    p1_rvalid = 1'b1;
                    p1_rdata  = rdata_reg;
                    p1_err    = ~legal;
                end else begin
                    p0_rvalid = 1'b1;
                    p0_rdata  = rdata_reg;
                    p0_err    = ~legal;
                end
            end
            default: ;
        endcase
    end

endmodule
